// File: rtl/branch_unit_bht_pkg.sv
// Shared encodings for the branch unit: funct3 branch codes, comparator select
// and 2-bit saturating counter states with their update rule.
package branch_unit_bht_pkg;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // funct3[2:1] selects the comparator; 01 is reserved
   typedef enum logic [1:0] {
      SEL_EQ   = 2'b00,
      SEL_RSVD = 2'b01,
      SEL_LT   = 2'b10,
      SEL_LTU  = 2'b11
   } cmp_sel_e;

   function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
      end else begin
         nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_unit_bht_counters.sv
// Direct-mapped array of 2-bit saturating direction counters with one
// combinational read port and one single-cycle update port.
module bht_counters
   import branch_unit_bht_pkg::*;
#(
   parameter int         ENTRIES = 64,
   parameter logic [1:0] INIT    = CNT_WNT,
   parameter int         IDX_W   = $clog2(ENTRIES)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_taken,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_taken
);

   logic [1:0] cnt_r [ENTRIES];

   // Reset loads every counter; otherwise at most one entry saturates up or down.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_r[i] <= INIT;
         end
      end else if (i_wr_en) begin
         cnt_r[i_wr_idx] <= cnt_next(cnt_r[i_wr_idx], i_wr_taken);
      end
   end

   assign o_rd_taken = cnt_r[i_rd_idx][1];

endmodule

// File: rtl/branch_unit_bht.sv
// Branch resolution with a one-cycle registered result, plus a bimodal
// direction predictor looked up at fetch and trained by resolved branches.
module branch_unit_bht
   import branch_unit_bht_pkg::*;
#(
   parameter int         XLEN        = 32,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] BHT_INIT    = 2'b01
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_fetch_pc,
   output logic            o_pred_taken,
   input  logic            i_valid,
   input  logic            i_stall,
   input  logic            i_kill,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_dat_a,
   input  logic [XLEN-1:0] i_dat_b,
   input  logic [2:0]      i_funct3,
   input  logic            i_branch,
   input  logic            i_jump,
   input  logic            i_pred_taken,
   output logic            o_valid,
   output logic            o_br_en,
   output logic            o_mispredict,
   output logic            o_illegal
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [IDX_W-1:0] fetch_idx_s;
   logic [IDX_W-1:0] res_idx_s;
   logic             unused_pc_bits_s;
   cmp_sel_e         sel_s;
   logic             eq_s;
   logic             lt_s;
   logic             ltu_s;
   logic             cond_s;
   logic             illegal_s;
   logic             taken_s;
   logic             accept_s;
   logic             bht_wr_s;

   // Word-aligned PCs: the two low bits never reach the index, upper bits alias.
   assign fetch_idx_s      = i_fetch_pc[IDX_W+1:2];
   assign res_idx_s        = i_pc[IDX_W+1:2];
   assign unused_pc_bits_s = ^{i_fetch_pc[XLEN-1:IDX_W+2], i_fetch_pc[1:0],
                               i_pc[XLEN-1:IDX_W+2], i_pc[1:0]};

   assign sel_s = cmp_sel_e'(i_funct3[2:1]);
   assign eq_s  = (i_dat_a == i_dat_b);
   assign lt_s  = ($signed(i_dat_a) < $signed(i_dat_b));
   assign ltu_s = (i_dat_a < i_dat_b);

   // Condition mux; funct3[0] inverts, the reserved select forces not-taken.
   always_comb begin
      cond_s    = 1'b0;
      illegal_s = 1'b0;
      case (sel_s)
         SEL_EQ:   cond_s = eq_s ^ i_funct3[0];
         SEL_LT:   cond_s = lt_s ^ i_funct3[0];
         SEL_LTU:  cond_s = ltu_s ^ i_funct3[0];
         SEL_RSVD: begin
            cond_s    = 1'b0;
            illegal_s = i_branch;
         end
         default: begin
            cond_s    = 1'b0;
            illegal_s = 1'b0;
         end
      endcase
   end

   assign taken_s  = i_jump | (i_branch & cond_s);
   assign accept_s = i_valid & ~i_kill & ~i_stall;
   // Jumps win over branches when both are flagged, so they never train.
   assign bht_wr_s = accept_s & i_branch & ~i_jump & ~illegal_s;

   // Result register: stall holds (even over kill), non-accepted cycles clear.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_br_en      <= 1'b0;
         o_mispredict <= 1'b0;
         o_illegal    <= 1'b0;
      end else if (i_stall) begin
         o_valid      <= o_valid;
         o_br_en      <= o_br_en;
         o_mispredict <= o_mispredict;
         o_illegal    <= o_illegal;
      end else if (accept_s) begin
         o_valid      <= 1'b1;
         o_br_en      <= taken_s;
         o_mispredict <= taken_s ^ i_pred_taken;
         o_illegal    <= illegal_s;
      end else begin
         o_valid      <= 1'b0;
         o_br_en      <= 1'b0;
         o_mispredict <= 1'b0;
         o_illegal    <= 1'b0;
      end
   end

   bht_counters #(
      .ENTRIES (BHT_ENTRIES),
      .INIT    (BHT_INIT),
      .IDX_W   (IDX_W)
   ) u_bht (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rd_idx   (fetch_idx_s),
      .o_rd_taken (o_pred_taken),
      .i_wr_en    (bht_wr_s),
      .i_wr_idx   (res_idx_s),
      .i_wr_taken (taken_s)
   );

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed bench for branch_unit_bht: expected results are queued when a step
// is driven and popped for comparison one edge later; predictions checked directly.
module tb_branch_unit_bht;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_fetch_pc;
   logic        o_pred_taken;
   logic        i_valid;
   logic        i_stall;
   logic        i_kill;
   logic [31:0] i_pc;
   logic [31:0] i_dat_a;
   logic [31:0] i_dat_b;
   logic [2:0]  i_funct3;
   logic        i_branch;
   logic        i_jump;
   logic        i_pred_taken;
   logic        o_valid;
   logic        o_br_en;
   logic        o_mispredict;
   logic        o_illegal;

   int errors = 0;
   int checks = 0;

   // {valid, br_en, mispredict, illegal}
   logic [3:0] exp_q [$];
   string      tag_q [$];
   logic [3:0] held = 4'b0000;

   localparam logic [31:0] M1 = 32'hFFFF_FFFF;

   branch_unit_bht dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_fetch_pc   (i_fetch_pc),
      .o_pred_taken (o_pred_taken),
      .i_valid      (i_valid),
      .i_stall      (i_stall),
      .i_kill       (i_kill),
      .i_pc         (i_pc),
      .i_dat_a      (i_dat_a),
      .i_dat_b      (i_dat_b),
      .i_funct3     (i_funct3),
      .i_branch     (i_branch),
      .i_jump       (i_jump),
      .i_pred_taken (i_pred_taken),
      .o_valid      (o_valid),
      .o_br_en      (o_br_en),
      .o_mispredict (o_mispredict),
      .o_illegal    (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic cond_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic r;
      case (f3)
         3'b000:  r = (a == b);
         3'b001:  r = (a != b);
         3'b100:  r = ($signed(a) < $signed(b));
         3'b101:  r = ($signed(a) >= $signed(b));
         3'b110:  r = (a < b);
         3'b111:  r = (a >= b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   task automatic step(input string tag, input logic rst, input logic valid, input logic stall,
                       input logic kill, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f3, input logic br,
                       input logic jmp, input logic pt);
      logic [3:0] e;
      logic       tk;
      logic       il;
      logic [3:0] got;
      i_rst_n = rst; i_valid = valid; i_stall = stall; i_kill = kill; i_pc = pc;
      i_dat_a = a; i_dat_b = b; i_funct3 = f3; i_branch = br; i_jump = jmp; i_pred_taken = pt;
      il = br & (f3[2:1] == 2'b01);
      tk = jmp | (br & cond_f(f3, a, b));
      if (!rst)                  e = 4'b0000;
      else if (stall)            e = held;
      else if (valid && !kill)   e = {1'b1, tk, tk ^ pt, il & ~jmp ? 1'b1 : il};
      else                       e = 4'b0000;
      held = e;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge i_clk);
      #1;
      got = {o_valid, o_br_en, o_mispredict, o_illegal};
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %b expected entry", tag, got);
      end else begin
         e = exp_q.pop_front();
         tag = tag_q.pop_front();
         checks++;
         assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed v/br/mp/il=%b expected %b", tag, got, e);
         end
      end
   endtask

   task automatic chk_pred(input string tag, input logic [31:0] fpc, input logic expv);
      i_fetch_pc = fpc;
      #1;
      checks++;
      assert (o_pred_taken === expv) else begin
         errors++;
         $error("FAIL %s: observed pred=%b expected %b", tag, o_pred_taken, expv);
      end
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_kill = 1'b0; i_pc = 32'h0;
      i_dat_a = 32'h0; i_dat_b = 32'h0; i_funct3 = 3'b000; i_branch = 1'b0;
      i_jump = 1'b0; i_pred_taken = 1'b0; i_fetch_pc = 32'h100;

      //    tag          rst   val   stl   kil   pc          a         b         f3      br    jmp   pt
      step("reset",      1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,    32'h0,    3'b000, 1'b0, 1'b0, 1'b0);
      chk_pred("pred_rst_100", 32'h100, 1'b0);
      step("idle",       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,    32'h0,    3'b000, 1'b0, 1'b0, 1'b0);

      // signed vs unsigned compare on idx 1, then saturation at 00
      step("blt",        1'b1, 1'b1, 1'b0, 1'b0, 32'h204,    M1,       32'h1,    3'b100, 1'b1, 1'b0, 1'b0);
      step("bltu",       1'b1, 1'b1, 1'b0, 1'b0, 32'h204,    M1,       32'h1,    3'b110, 1'b1, 1'b0, 1'b0);
      step("bge",        1'b1, 1'b1, 1'b0, 1'b0, 32'h204,    M1,       32'h1,    3'b101, 1'b1, 1'b0, 1'b1);
      chk_pred("pred_204_a", 32'h204, 1'b0);
      step("bgeu",       1'b1, 1'b1, 1'b0, 1'b0, 32'h208,    M1,       32'h1,    3'b111, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_208", 32'h208, 1'b1);
      step("bne_nt",     1'b1, 1'b1, 1'b0, 1'b0, 32'h204,    32'h5,    32'h5,    3'b001, 1'b1, 1'b0, 1'b0);
      step("beq_204_1",  1'b1, 1'b1, 1'b0, 1'b0, 32'h204,    32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_204_b", 32'h204, 1'b0);
      step("beq_204_2",  1'b1, 1'b1, 1'b0, 1'b0, 32'h204,    32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_204_c", 32'h204, 1'b1);

      // saturation at 11 on 0x40, alias at 0x140
      chk_pred("pred_40_init", 32'h40, 1'b0);
      step("beq_40_1",   1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_40_1", 32'h40, 1'b1);
      step("beq_40_2",   1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b1);
      step("beq_40_3",   1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b1);
      chk_pred("pred_40_3", 32'h40, 1'b1);
      chk_pred("pred_140_alias", 32'h140, 1'b1);
      step("bne_40_1",   1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b001, 1'b1, 1'b0, 1'b1);
      chk_pred("pred_40_dn1", 32'h40, 1'b1);
      step("bne_40_2",   1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b001, 1'b1, 1'b0, 1'b1);
      chk_pred("pred_40_dn2", 32'h40, 1'b0);

      // stall holds outputs and table, also over kill; kill alone squashes
      step("beq_80",     1'b1, 1'b1, 1'b0, 1'b0, 32'h80,     32'h7,    32'h7,    3'b000, 1'b1, 1'b0, 1'b1);
      step("stall_1",    1'b1, 1'b1, 1'b1, 1'b0, 32'h80,     32'h1,    32'h1,    3'b100, 1'b1, 1'b0, 1'b1);
      step("stall_2",    1'b1, 1'b1, 1'b1, 1'b0, 32'h80,     32'h1,    32'h1,    3'b100, 1'b1, 1'b0, 1'b1);
      step("stall_kill", 1'b1, 1'b1, 1'b1, 1'b1, 32'h80,     32'h1,    32'h1,    3'b100, 1'b1, 1'b0, 1'b1);
      chk_pred("pred_80_stall", 32'h80, 1'b1);
      step("kill",       1'b1, 1'b1, 1'b0, 1'b1, 32'h84,     32'h3,    32'h3,    3'b000, 1'b1, 1'b0, 1'b0);
      step("kill_stall0",1'b1, 1'b0, 1'b1, 1'b0, 32'h84,     32'h3,    32'h3,    3'b000, 1'b1, 1'b0, 1'b0);
      step("kill_again", 1'b1, 1'b1, 1'b0, 1'b1, 32'h84,     32'h3,    32'h3,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_84_kill", 32'h84, 1'b0);

      // jumps never train; branch+jump counts as a jump
      step("jump",       1'b1, 1'b1, 1'b0, 1'b0, 32'h88,     32'h1,    32'h2,    3'b000, 1'b0, 1'b1, 1'b0);
      step("br_jump",    1'b1, 1'b1, 1'b0, 1'b0, 32'h88,     32'h1,    32'h2,    3'b000, 1'b1, 1'b1, 1'b1);
      chk_pred("pred_88_jump", 32'h88, 1'b0);

      // reserved funct3: illegal, not taken, no training
      step("illegal_010",1'b1, 1'b1, 1'b0, 1'b0, 32'h8C,     32'h5,    32'h5,    3'b010, 1'b1, 1'b0, 1'b1);
      step("illegal_011",1'b1, 1'b1, 1'b0, 1'b0, 32'h8C,     32'h5,    32'h5,    3'b011, 1'b1, 1'b0, 1'b1);
      step("beq_8c",     1'b1, 1'b1, 1'b0, 1'b0, 32'h8C,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_8c", 32'h8C, 1'b1);

      // invalid cycle does not train
      step("invalid",    1'b1, 1'b0, 1'b0, 1'b0, 32'h90,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_90", 32'h90, 1'b0);

      // reset mid-stream wins over a valid taken branch
      step("beq_40_pre", 1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      step("mid_reset",  1'b0, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_40_rst", 32'h40, 1'b0);
      chk_pred("pred_80_rst", 32'h80, 1'b0);
      chk_pred("pred_8c_rst", 32'h8C, 1'b0);
      step("post_reset", 1'b1, 1'b1, 1'b0, 1'b0, 32'h40,     32'h5,    32'h5,    3'b000, 1'b1, 1'b0, 1'b0);
      chk_pred("pred_40_post", 32'h40, 1'b1);
      step("drain",      1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,    32'h0,    3'b000, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
